aes_byte_sequencer: RTL

Control FSM for the byte-serial AES-128 encryption datapath. It drives the 8-bit input-select mux that chooses between a fresh plaintext byte and the feedback byte from the round logic. It also generates the byte index, round number, per-round mode strobes and key-schedule steps, and it handles the input and output byte-stream handshakes. It carries no data itself; it sits beside the state-byte register file, the 8-bit mux, the round logic and the key expander.

---
 rtl/aes_ctrl_pkg.sv | 21 ++
 rtl/mod_counter.sv | 47 ++++
 rtl/aes_byte_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the byte-serial AES-128 control path.
//   state_e     : controller FSM states
//   NR, NB      : AES-128 round count and bytes per block
//   ByteIdxW    : width of the byte index counter
//   RoundW      : width of the round counter
package aes_ctrl_pkg;

   localparam int unsigned NR       = 10;
   localparam int unsigned NB       = 16;
   localparam int unsigned ByteIdxW = 4;
   localparam int unsigned RoundW   = 4;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StKey,
      StRound,
      StOut
   } state_e;

endpackage

// File: rtl/mod_counter.sv
// Small up-counter with clear, increment and terminal-count flag.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force count to zero (wins over inc)
//   inc      : advance one step
//   count    : current value
//   at_max   : count equals Max
// At Max, an increment wraps to zero, or holds when Saturate is set.
module mod_counter #(
   parameter int unsigned Width    = 4,
   parameter int unsigned Max      = 15,
   parameter bit          Saturate = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [Width-1:0] count,
   output logic             at_max
);

   logic [Width-1:0] count_q, count_d;

   assign at_max = (count_q == Width'(Max));
   assign count  = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         if (at_max) begin
            count_d = Saturate ? count_q : '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/aes_byte_sequencer.sv
// Control FSM for the byte-serial AES-128 encryption datapath.
// Carries no data: it steers the plaintext/feedback mux, the state-byte
// write enable, the round-mode strobes and the key expander, and runs the
// input and output byte handshakes.
//   clk, rst             : clock, synchronous active-high reset
//   start                : begin a block (IDLE only)
//   in_valid / in_ready  : plaintext byte handshake (LOAD only)
//   out_valid / out_ready: ciphertext byte handshake (OUT only)
//   mux_sel              : 1 = plaintext byte, 0 = round feedback byte
//   st_we                : state-byte write enable at byte_idx
//   byte_idx, round      : current byte position and round number
//   ark_only, mc_bypass  : round-0 and final-round datapath modes
//   key_load, key_step   : key expander control
//   busy, done           : not-idle flag, final-output-beat pulse
module aes_byte_sequencer
   import aes_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                mux_sel,
   output logic                st_we,
   output logic [ByteIdxW-1:0] byte_idx,
   output logic [RoundW-1:0]   round,
   output logic                ark_only,
   output logic                mc_bypass,
   output logic                key_load,
   output logic                key_step,
   output logic                busy,
   output logic                done
);

   state_e state_q, state_d;

   logic byte_clr, byte_inc, byte_last;
   logic round_clr, round_inc, round_last;

   // Byte position within the block, wraps NB-1 -> 0.
   mod_counter #(
      .Width    (ByteIdxW),
      .Max      (NB - 1),
      .Saturate (1'b0)
   ) u_byte_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (byte_clr),
      .inc    (byte_inc),
      .count  (byte_idx),
      .at_max (byte_last)
   );

   // Round number; never advanced past NR because KEY is skipped then.
   mod_counter #(
      .Width    (RoundW),
      .Max      (NR),
      .Saturate (1'b1)
   ) u_round_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (round_clr),
      .inc    (round_inc),
      .count  (round),
      .at_max (round_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            // in_ready is always high here, so in_valid alone is an accept.
            if (in_valid && byte_last) begin
               state_d = StKey;
            end
         end
         StKey: begin
            state_d = StRound;
         end
         StRound: begin
            if (byte_last) begin
               state_d = round_last ? StOut : StKey;
            end
         end
         StOut: begin
            if (out_ready && byte_last) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output decode and counter control.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      mux_sel   = 1'b0;
      st_we     = 1'b0;
      ark_only  = 1'b0;
      mc_bypass = 1'b0;
      key_load  = 1'b0;
      key_step  = 1'b0;
      done      = 1'b0;
      byte_clr  = 1'b0;
      byte_inc  = 1'b0;
      round_clr = 1'b0;
      round_inc = 1'b0;
      busy      = (state_q != StIdle);
      unique case (state_q)
         StIdle: begin
            // Event strobes are masked during reset so none leak out.
            if (start && !rst) begin
               key_load  = 1'b1;
               byte_clr  = 1'b1;
               round_clr = 1'b1;
            end
         end
         StLoad: begin
            in_ready = 1'b1;
            mux_sel  = 1'b1;
            ark_only = 1'b1;
            st_we    = in_valid;
            byte_inc = in_valid;
         end
         StKey: begin
            key_step  = 1'b1;
            round_inc = 1'b1;
         end
         StRound: begin
            st_we     = 1'b1;
            mc_bypass = round_last;
            byte_inc  = 1'b1;
         end
         StOut: begin
            out_valid = 1'b1;
            byte_inc  = out_ready;
            done      = out_ready && byte_last && !rst;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
